// File: rtl/code_lock_param.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_param
//  Purpose  : Parameterised digit-code lock. Digits are submitted on rising
//             edges of enter, checked against CODE without revealing where
//             an error occurred, and the result drives UNLOCKED or a timed
//             ERROR hold. Build with CODE_LOCK_LOCKOUT_EN defined to add a
//             failed-attempt counter and a timed LOCKOUT state.
//  Revision : 1.0  initial release
// ============================================================================
module code_lock_param #(
  parameter int                          CODE_LEN    = 4,
  parameter int                          DIGIT_W     = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE        = 16'h1234,
  parameter int                          ERR_CYC     = 8,
  parameter int                          MAX_TRIES   = 3,
  parameter int                          LOCKOUT_CYC = 1000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DIGIT_W-1:0]              in_digit,
  input  logic                            enter,
  input  logic                            clear,
  output logic                            locked_led,
  output logic                            unlocked_led,
  output logic                            error_led,
  output logic                            lockout_led,
  output logic [2:0]                      state_leds,
  output logic [$clog2(CODE_LEN+1)-1:0]   digit_idx
);

  localparam int c_idx_w    = $clog2(CODE_LEN + 1);
  localparam int c_hold_max = (ERR_CYC > LOCKOUT_CYC) ? ERR_CYC : LOCKOUT_CYC;
  localparam int c_cnt_w    = $clog2(c_hold_max + 1);

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(CODE_LEN - 1);
  localparam logic [c_cnt_w-1:0] c_err_last = c_cnt_w'(ERR_CYC - 1);
`ifdef CODE_LOCK_LOCKOUT_EN
  localparam int                 c_fail_w    = $clog2(MAX_TRIES + 1);
  localparam logic [c_fail_w-1:0] c_max_tries = c_fail_w'(MAX_TRIES);
  localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCKOUT_CYC - 1);
`endif

  // Reject parameter sets the hold/index logic cannot represent.
  generate
    if (CODE_LEN < 1 || CODE_LEN > 8 || ERR_CYC < 1 || MAX_TRIES < 1 || LOCKOUT_CYC < 1) begin : g_bad_params
      $error("code_lock_param: parameter out of range");
    end
  endgenerate

  // State encoding doubles as the state_leds pattern.
  typedef enum logic [2:0] {
    S_IDLE     = 3'b001,
    S_ENTRY    = 3'b010,
    S_UNLOCKED = 3'b100,
    S_ERROR    = 3'b011
`ifdef CODE_LOCK_LOCKOUT_EN
    , S_LOCKOUT = 3'b111
`endif
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_idx_w-1:0]   r_idx, w_idx_nxt;
  logic                 r_flag, w_flag_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_enter_q;
  logic                 r_armed;
  logic                 w_submit;
  logic                 w_mismatch;
  logic [DIGIT_W-1:0]   w_code_digit;
`ifdef CODE_LOCK_LOCKOUT_EN
  logic [c_fail_w-1:0]  r_fail, w_fail_nxt;
`endif

  // r_armed stays low while enter has been high continuously since reset,
  // so a held key cannot masquerade as a fresh press after reset release.
  assign w_submit   = enter & ~r_enter_q & r_armed;
  assign w_mismatch = (in_digit != w_code_digit);

  // Select the expected digit for the current position; digit 0 is the MSBs.
  always_comb begin
    w_code_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_code_digit = CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Register the FSM state, entry progress, hold counter and enter history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_flag    <= 1'b0;
      r_cnt     <= '0;
      r_enter_q <= 1'b0;
      r_armed   <= ~enter;
`ifdef CODE_LOCK_LOCKOUT_EN
      r_fail    <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_flag    <= w_flag_nxt;
      r_cnt     <= w_cnt_nxt;
      r_enter_q <= enter;
      r_armed   <= r_armed | ~enter;
`ifdef CODE_LOCK_LOCKOUT_EN
      r_fail    <= w_fail_nxt;
`endif
    end
  end

  // Next-state logic; clear takes priority over a simultaneous submit.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_flag_nxt  = r_flag;
    w_cnt_nxt   = r_cnt;
`ifdef CODE_LOCK_LOCKOUT_EN
    w_fail_nxt  = r_fail;
`endif
    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_flag_nxt  = 1'b0;
        end else if (w_submit) begin
          if (r_idx != c_last_idx) begin
            w_state_nxt = S_ENTRY;
            w_idx_nxt   = r_idx + 1'b1;
            w_flag_nxt  = r_flag | w_mismatch;
          end else begin
            w_idx_nxt  = '0;
            w_flag_nxt = 1'b0;
            w_cnt_nxt  = '0;
            if (r_flag | w_mismatch) begin
              w_state_nxt = S_ERROR;
`ifdef CODE_LOCK_LOCKOUT_EN
              if (r_fail != c_max_tries) begin
                w_fail_nxt = r_fail + 1'b1;
              end
`endif
            end else begin
              w_state_nxt = S_UNLOCKED;
`ifdef CODE_LOCK_LOCKOUT_EN
              w_fail_nxt  = '0;
`endif
            end
          end
        end
      end
      S_UNLOCKED: begin
        if (clear || w_submit) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        if (r_cnt == c_err_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
`ifdef CODE_LOCK_LOCKOUT_EN
          if (r_fail >= c_max_tries) begin
            w_state_nxt = S_LOCKOUT;
          end
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef CODE_LOCK_LOCKOUT_EN
      S_LOCKOUT: begin
        if (r_cnt == c_lock_last) begin
          w_cnt_nxt   = '0;
          w_fail_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_flag_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the state and index registers only.
  assign locked_led   = (r_state == S_IDLE) || (r_state == S_ENTRY);
  assign unlocked_led = (r_state == S_UNLOCKED);
  assign error_led    = (r_state == S_ERROR);
`ifdef CODE_LOCK_LOCKOUT_EN
  assign lockout_led  = (r_state == S_LOCKOUT);
`else
  assign lockout_led  = 1'b0;
`endif
  assign state_leds   = r_state;
  assign digit_idx    = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_code_lock_param
//  Purpose  : Self-checking bench for code_lock_param against a queue-based
//             behavioural model of the lock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_code_lock_param;

  localparam int          CODE_LEN    = 4;
  localparam int          DIGIT_W     = 4;
  localparam logic [15:0] CODE        = 16'h1234;
  localparam int          ERR_CYC     = 4;
  localparam int          MAX_TRIES   = 3;
  localparam int          LOCKOUT_CYC = 16;
`ifdef CODE_LOCK_LOCKOUT_EN
  localparam bit          LOCK_EN     = 1'b1;
`else
  localparam bit          LOCK_EN     = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ENTRY = 1, M_UNLOCKED = 2, M_ERROR = 3, M_LOCKOUT = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enter = 1'b0;
  logic               clear = 1'b0;
  logic [DIGIT_W-1:0] in_digit = '0;
  logic               locked_led, unlocked_led, error_led, lockout_led;
  logic [2:0]         state_leds;
  logic [2:0]         digit_idx;
  logic [9:0]         obs;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: digits collected so far, remaining hold cycles, failures.
  int m_mode  = M_IDLE;
  int m_digits[$];
  int m_hold  = 0;
  int m_fails = 0;
  bit m_prev  = 1'b0;
  bit m_armed = 1'b0;

  always #5 clk = ~clk;

  code_lock_param #(
    .CODE_LEN(CODE_LEN), .DIGIT_W(DIGIT_W), .CODE(CODE),
    .ERR_CYC(ERR_CYC), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .in_digit(in_digit), .enter(enter), .clear(clear),
    .locked_led(locked_led), .unlocked_led(unlocked_led), .error_led(error_led),
    .lockout_led(lockout_led), .state_leds(state_leds), .digit_idx(digit_idx)
  );

  assign obs = {locked_led, unlocked_led, error_led, lockout_led, state_leds, digit_idx};

  function automatic int code_digit(input int i);
    logic [15:0] c;
    c = CODE;
    return int'(c[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W]);
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [3:0] leds;
    logic [2:0] st;
    case (m_mode)
      M_IDLE:     begin leds = 4'b1000; st = 3'b001; end
      M_ENTRY:    begin leds = 4'b1000; st = 3'b010; end
      M_UNLOCKED: begin leds = 4'b0100; st = 3'b100; end
      M_ERROR:    begin leds = 4'b0010; st = 3'b011; end
      default:    begin leds = 4'b0001; st = 3'b111; end
    endcase
    return {leds, st, 3'(m_digits.size())};
  endfunction

  task automatic model_step(input bit e, input bit c, input bit r, input int d);
    bit sub;
    bit ok;
    if (r) begin
      m_mode = M_IDLE; m_digits.delete(); m_hold = 0; m_fails = 0;
      m_prev = 1'b0; m_armed = !e;
      return;
    end
    sub    = e && !m_prev && m_armed;
    m_prev = e;
    if (!e) m_armed = 1'b1;
    case (m_mode)
      M_IDLE, M_ENTRY: begin
        if (c) begin
          m_mode = M_IDLE;
          m_digits.delete();
        end else if (sub) begin
          m_digits.push_back(d);
          if (m_digits.size() == CODE_LEN) begin
            ok = 1'b1;
            foreach (m_digits[i]) if (m_digits[i] != code_digit(i)) ok = 1'b0;
            m_digits.delete();
            if (ok) begin
              m_mode = M_UNLOCKED; m_fails = 0;
            end else begin
              m_mode = M_ERROR; m_hold = ERR_CYC;
              if (m_fails < MAX_TRIES) m_fails++;
            end
          end else begin
            m_mode = M_ENTRY;
          end
        end
      end
      M_UNLOCKED: if (c || sub) m_mode = M_IDLE;
      M_ERROR: begin
        m_hold--;
        if (m_hold == 0) begin
          if (LOCK_EN && m_fails >= MAX_TRIES) begin
            m_mode = M_LOCKOUT; m_hold = LOCKOUT_CYC;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      default: begin
        m_hold--;
        if (m_hold == 0) begin m_mode = M_IDLE; m_fails = 0; end
      end
    endcase
  endtask

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic drive(input bit e, input bit c, input bit r, input logic [3:0] d);
    reset = r; enter = e; clear = c; in_digit = d;
    model_step(e, c, r, int'(d));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    if (obs !== 10'b1000_001_000) begin
      n_errors++; $display("FAIL reset_outputs: got %b want %b", obs, 10'b1000_001_000);
    end
    n_checks++;
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    if (obs !== exp_vec()) begin
      n_errors++; $display("FAIL reset_idle_clear: got %b want %b", obs, exp_vec());
    end
    n_checks++;
  endtask

  task automatic test_unlock();
    int good[4] = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'(good[i]));
      if (digit_idx !== 3'((i < 3) ? i + 1 : 0)) begin
        n_errors++; $display("FAIL unlock_idx%0d: got %0d want %0d", i, digit_idx, (i < 3) ? i + 1 : 0);
      end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL unlock_rise%0d: got %b want %b", i, obs, exp_vec());
      end
      n_checks++;
      drive(1'b0, 1'b0, 1'b0, 4'h0);
    end
    if (unlocked_led !== 1'b1 || state_leds !== 3'b100) begin
      n_errors++; $display("FAIL unlock_state: got led=%b st=%b want led=1 st=100", unlocked_led, state_leds);
    end
    n_checks++;
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    if (state_leds !== 3'b001 || locked_led !== 1'b1) begin
      n_errors++; $display("FAIL unlock_relock: got st=%b want 001", state_leds);
    end
    n_checks++;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_wrong_code();
    int bad[4] = '{1, 9, 3, 4};
    int err_cycles;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'(bad[i]));
      if (error_led !== 1'b0 || digit_idx !== 3'(i + 1)) begin
        n_errors++; $display("FAIL wrong_early%0d: got err=%b idx=%0d want err=0 idx=%0d", i, error_led, digit_idx, i + 1);
      end
      n_checks++;
      drive(1'b0, 1'b0, 1'b0, 4'h0);
    end
    drive(1'b1, 1'b0, 1'b0, 4'(bad[3]));
    if (obs !== exp_vec() || error_led !== 1'b1) begin
      n_errors++; $display("FAIL wrong_enter_error: got %b want %b", obs, exp_vec());
    end
    n_checks++;
    err_cycles = 1;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h0);
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL wrong_hold: got %b want %b", obs, exp_vec());
      end
      n_checks++;
      if (error_led === 1'b1) err_cycles++;
      else break;
    end
    if (err_cycles != ERR_CYC || state_leds !== 3'b001) begin
      n_errors++; $display("FAIL wrong_err_len: got %0d cycles st=%b want %0d st=001", err_cycles, state_leds, ERR_CYC);
    end
    n_checks++;
  endtask

  // Enter a bad code then wait out ERROR (bounded), checking against the model.
  task automatic bad_code_and_wait(input string tag);
    int bad[4] = '{4, 3, 2, 1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'(bad[i]));
      drive(1'b0, 1'b0, 1'b0, 4'h0);
    end
    for (int k = 0; k < 20 && error_led === 1'b1; k++) begin
      drive(1'b0, 1'b0, 1'b0, 4'h0);
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL %s_err: got %b want %b", tag, obs, exp_vec());
      end
      n_checks++;
    end
  endtask

  task automatic test_lockout();
    int lk;
    int good[4] = '{1, 2, 3, 4};
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    for (int t = 0; t < 3; t++) begin
      bad_code_and_wait("lockout_try");
      if (state_leds !== ((t == 2 && LOCK_EN) ? 3'b111 : 3'b001)) begin
        n_errors++; $display("FAIL lockout_after_try%0d: got %b want %b", t, state_leds, (t == 2 && LOCK_EN) ? 3'b111 : 3'b001);
      end
      n_checks++;
    end
    lk = 0;
    for (int k = 0; k < 40 && lockout_led === 1'b1; k++) begin
      lk++;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)));
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL lockout_hold: got %b want %b", obs, exp_vec());
      end
      n_checks++;
    end
    if (lk != (LOCK_EN ? LOCKOUT_CYC : 0)) begin
      n_errors++; $display("FAIL lockout_len: got %0d want %0d", lk, LOCK_EN ? LOCKOUT_CYC : 0);
    end
    n_checks++;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'(good[i]));
      drive(1'b0, 1'b0, 1'b0, 4'h0);
    end
    if (unlocked_led !== 1'b1 || obs !== exp_vec()) begin
      n_errors++; $display("FAIL lockout_unlock_after: got %b want %b", obs, exp_vec());
    end
    n_checks++;
  endtask

  task automatic test_clear_submit();
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    bad_code_and_wait("clr_first");
    drive(1'b1, 1'b0, 1'b0, 4'h1);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h2);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 4'h3);
    if (state_leds !== 3'b001 || digit_idx !== 3'd0 || obs !== exp_vec()) begin
      n_errors++; $display("FAIL clear_wins: got st=%b idx=%0d want st=001 idx=0", state_leds, digit_idx);
    end
    n_checks++;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    bad_code_and_wait("clr_second");
    if (state_leds !== 3'b001) begin
      n_errors++; $display("FAIL clear_not_failure: got st=%b want 001", state_leds);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    int bad[4] = '{1, 9, 3, 4};
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h1);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h2);
    drive(1'b1, 1'b0, 1'b1, 4'h3);
    if (obs !== 10'b1000_001_000) begin
      n_errors++; $display("FAIL reset_mid_entry: got %b want %b", obs, 10'b1000_001_000);
    end
    n_checks++;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 4'h1);
    if (digit_idx !== 3'd0 || state_leds !== 3'b001) begin
      n_errors++; $display("FAIL reset_held_enter: got idx=%0d st=%b want idx=0 st=001", digit_idx, state_leds);
    end
    n_checks++;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h1);
    if (digit_idx !== 3'd1 || obs !== exp_vec()) begin
      n_errors++; $display("FAIL reset_rearm: got idx=%0d want 1", digit_idx);
    end
    n_checks++;
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'(bad[i]));
      drive(1'b0, 1'b0, 1'b0, 4'h0);
    end
    drive(1'b1, 1'b0, 1'b0, 4'(bad[3]));
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 1'b1, 4'h0);
    if (obs !== 10'b1000_001_000 || obs !== exp_vec()) begin
      n_errors++; $display("FAIL reset_mid_error: got %b want %b", obs, 10'b1000_001_000);
    end
    n_checks++;
    drive(1'b1, 1'b0, 1'b0, 4'h1);
    drive(1'b1, 1'b0, 1'b0, 4'h1);
    if (digit_idx !== 3'd0 || locked_led !== 1'b1) begin
      n_errors++; $display("FAIL reset_err_held: got idx=%0d locked=%b want idx=0 locked=1", digit_idx, locked_led);
    end
    n_checks++;
  endtask

  task automatic test_random();
    bit e, c, r;
    logic [3:0] d;
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    for (int k = 0; k < 800; k++) begin
      e = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 199) == 0);
      d = ($urandom_range(0, 5) != 0) ? 4'(code_digit(m_digits.size())) : 4'($urandom_range(0, 15));
      drive(e, c, r, d);
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL random_cyc%0d: got %b want %b", k, obs, exp_vec());
      end
      n_checks++;
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_code();
    test_lockout();
    test_clear_submit();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/code_lock_param.md
CODE_LOCK_PARAM -- requirements
Module: code_lock_param

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, number of digits in the code (1..8).
REQ-002 SHALL have parameter DIGIT_W, default 4, width of one digit.
REQ-003 SHALL have parameter CODE, default 16'h1234, CODE_LEN*DIGIT_W bits; digit 0 is the most significant DIGIT_W bits.
REQ-004 SHALL have parameter ERR_CYC, default 8, number of cycles the ERROR state is held (>=1).
REQ-005 SHALL have parameter MAX_TRIES, default 3, number of consecutive failed codes before lockout (>=1).
REQ-006 SHALL have parameter LOCKOUT_CYC, default 1000, number of cycles the LOCKOUT state is held (>=1).
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port in_digit, input, DIGIT_W, the digit presented with enter.
REQ-010 SHALL have port enter, input, 1, level; each rising edge submits in_digit.
REQ-011 SHALL have port clear, input, 1, level; abandons entry or relocks.
REQ-012 SHALL have port locked_led, output, 1, high in IDLE and ENTRY.
REQ-013 SHALL have port unlocked_led, output, 1, high in UNLOCKED.
REQ-014 SHALL have port error_led, output, 1, high in ERROR.
REQ-015 SHALL have port lockout_led, output, 1, high in LOCKOUT.
REQ-016 SHALL have port state_leds, output, 3, state code: IDLE=001, ENTRY=010, UNLOCKED=100, ERROR=011, LOCKOUT=111.
REQ-017 SHALL have port digit_idx, output, clog2(CODE_LEN+1), number of digits accepted so far.

Function
REQ-018 Edge detect: enter is registered into enter_q; a submit event is enter & ~enter_q. The state update SHALL occur at the same clk edge where enter is first sampled high.
REQ-019 All outputs SHALL be Moore, decoded only from the state register and the index register.
REQ-020 A submit in IDLE or ENTRY SHALL compare in_digit with CODE digit[digit_idx] and OR a mismatch into a sticky flag. Entry SHALL NOT abort on a wrong digit, so the location of the error is not revealed.
REQ-021 If digit_idx < CODE_LEN-1, the submit SHALL increment digit_idx and enter ENTRY.
REQ-022 If digit_idx = CODE_LEN-1 and (flag | current mismatch) = 0, the block SHALL enter UNLOCKED; otherwise it SHALL enter ERROR. In both cases digit_idx and flag SHALL be cleared.
REQ-023 CODE_LEN=1: a single submit decides UNLOCKED or ERROR directly from IDLE.
REQ-024 UNLOCKED: a submit or clear SHALL return to IDLE.
REQ-025 ERROR: the block SHALL ignore enter and clear, hold for exactly ERR_CYC cycles, then go to IDLE.
REQ-026 clear in ENTRY SHALL return to IDLE, clear index and flag, and SHALL NOT count as a failure. clear in IDLE has no effect.
REQ-027 If clear and a submit occur in the same cycle, clear SHALL win and the digit SHALL be discarded.
REQ-028 The hold counter SHALL be wide enough for max(ERR_CYC, LOCKOUT_CYC) and SHALL NOT wrap.

Reset
REQ-029 reset SHALL force IDLE, digit_idx=0, flag=0, enter_q=0, counters=0, and fail count=0.
REQ-030 Outputs after reset SHALL be locked_led=1, others 0, state_leds=001. reset SHALL win over every other input, mid-entry or mid-hold.
REQ-031 enter held high through reset release SHALL NOT produce a submit until it goes low and rises again.

Configuration
REQ-032 Macro CODE_LOCK_LOCKOUT_EN defined: a fail counter increments on each ERROR entry and clears on UNLOCKED entry.
REQ-033 With the macro defined, when the counter reaches MAX_TRIES, ERROR expiry SHALL go to LOCKOUT instead of IDLE. LOCKOUT ignores all inputs for LOCKOUT_CYC cycles, then goes to IDLE with the counter cleared.
REQ-034 Macro undefined: no fail counter and no LOCKOUT state; ERROR always returns to IDLE; lockout_led is tied to 0.

Verification (CODE=16'h1234, CODE_LEN=4, DIGIT_W=4, ERR_CYC=4, MAX_TRIES=3, LOCKOUT_CYC=16)
REQ-035 Pulse digits 1,2,3,4 -> digit_idx steps 1,2,3; unlocked_led=1 and state_leds=100 at the edge of the 4th rise.
REQ-036 Pulse digits 1,9,3,4 -> no early error while digit_idx runs 1..3; ERROR entered on the 4th digit, error_led high for exactly 4 cycles, then IDLE.
REQ-037 Three wrong codes with the macro defined -> LOCKOUT (state_leds=111) for 16 cycles with enter pulses ignored, then a correct code unlocks. With the macro undefined -> IDLE after each ERROR.
REQ-038 Digits 1,2 then clear and enter high in the same cycle -> IDLE, digit_idx=0, fail count unchanged.
REQ-039 Assert reset mid-ERROR and mid-entry while enter is held high -> IDLE next cycle, locked_led=1, and no submit until enter goes low and rises again.
